// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the round-robin arbiter and the UART TX.
// The slave modport is the arbiter's view. The master modport is the requester/UART side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*DATA_BITS-1:0] req_tdata;
  logic [NUM_REQ-1:0]           req_tvalid;
  logic [NUM_REQ-1:0]           req_tlast;
  logic [NUM_REQ-1:0]           req_tready;
  logic [DATA_BITS-1:0]         tx_tdata;
  logic                         tx_tdata_valid;
  logic                         tx_ready;
  logic                         grant_active;
  logic [ID_BITS-1:0]           grant_id;
  logic                         timeout_pulse;

  modport slave (
    input  req_tdata, req_tvalid, req_tlast, tx_ready,
    output req_tready, tx_tdata, tx_tdata_valid, grant_active, grant_id, timeout_pulse
  );

  modport master (
    output req_tdata, req_tvalid, req_tlast, tx_ready,
    input  req_tready, tx_tdata, tx_tdata_valid, grant_active, grant_id, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX between NUM_REQ byte-stream requesters.
// A grant is held until the owner's tlast byte is accepted, or until the owner stays idle for HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int HOLD_TIMEOUT = 1000
) (
  input logic              clk,
  input logic              rstn,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_BITS = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST   = (HOLD_TIMEOUT > 0) ? CNT_BITS'(HOLD_TIMEOUT - 1) : '0;
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
  localparam logic [ID_BITS-1:0]  ID_LAST    = ID_BITS'(NUM_REQ - 1);
  localparam bit                  TIMEOUT_EN = (HOLD_TIMEOUT > 0);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state;
  logic [ID_BITS-1:0]    grant_id;
  logic [ID_BITS-1:0]    last_grant;
  logic [ID_BITS-1:0]    next_id;
  logic [ID_BITS-1:0]    rr_cand;
  logic                  found;
  logic [CNT_BITS-1:0]   hold_cnt;
  logic                  timeout_pulse;
  logic [DATA_BITS-1:0]  req_bytes [NUM_REQ];
  logic                  locked;
  logic                  cur_valid;
  logic                  cur_last;
  logic                  xfer;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = bus.req_tdata[g*DATA_BITS +: DATA_BITS];
  end

  assign locked    = (state == LOCKED);
  assign cur_valid = bus.req_tvalid[grant_id];
  assign cur_last  = bus.req_tlast[grant_id];
  assign xfer      = locked && cur_valid && bus.tx_ready;

  // Search starts one past the previous owner, so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    rr_cand = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = (rr_cand == ID_LAST) ? '0 : rr_cand + ID_BITS'(1);
      if (!found && bus.req_tvalid[rr_cand]) begin
        found   = 1'b1;
        next_id = rr_cand;
      end
    end
  end

  always_comb begin
    bus.req_tready = '0;
    if (locked) begin
      bus.req_tready[grant_id] = bus.tx_ready;
    end
  end

  assign bus.tx_tdata       = locked ? req_bytes[grant_id] : '0;
  assign bus.tx_tdata_valid = locked && cur_valid;
  assign bus.grant_active   = locked;
  assign bus.grant_id       = grant_id;
  assign bus.timeout_pulse  = timeout_pulse;

  // A tlast release takes priority over a timeout that expires in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      grant_id      <= '0;
      last_grant    <= ID_LAST;
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= next_id;
            hold_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && cur_last) begin
            last_grant <= grant_id;
            hold_cnt   <= '0;
            state      <= IDLE;
          end else if (TIMEOUT_EN && !cur_valid && (hold_cnt == CNT_LAST)) begin
            last_grant    <= grant_id;
            hold_cnt      <= '0;
            timeout_pulse <= 1'b1;
            state         <= IDLE;
          end else if (cur_valid) begin
            hold_cnt <= '0;
          end else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + CNT_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, message locking, a slow UART, hold timeout and mid-message reset.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int DATA_BITS    = 8;
  localparam int HOLD_TIMEOUT = 8;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   xfers;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_BITS(DATA_BITS),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_stimulus(input int idx, input logic valid, input logic [7:0] data, input logic last);
    bus.req_tvalid[idx] = valid;
    bus.req_tdata[idx*DATA_BITS +: DATA_BITS] = data;
    bus.req_tlast[idx] = last;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_active"}, 32'(bus.grant_active), 32'd0);
    check_output({tag, "_valid"}, 32'(bus.tx_tdata_valid), 32'd0);
    check_output({tag, "_ready"}, 32'(bus.req_tready), 32'd0);
    check_output({tag, "_data"}, 32'(bus.tx_tdata), 32'd0);
  endtask

  task automatic check_grant(input string tag, input int id, input logic [7:0] data,
                             input logic valid, input logic [3:0] ready);
    check_output({tag, "_active"}, 32'(bus.grant_active), 32'd1);
    check_output({tag, "_id"}, 32'(bus.grant_id), 32'(id));
    check_output({tag, "_data"}, 32'(bus.tx_tdata), 32'(data));
    check_output({tag, "_valid"}, 32'(bus.tx_tdata_valid), 32'(valid));
    check_output({tag, "_ready"}, 32'(bus.req_tready), 32'(ready));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    xfers          = 0;
    rstn           = 1'b0;
    bus.req_tdata  = '0;
    bus.req_tvalid = '0;
    bus.req_tlast  = '0;
    bus.tx_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    check_output("rst_id", 32'(bus.grant_id), 32'd0);
    check_output("rst_pulse", 32'(bus.timeout_pulse), 32'd0);
    rstn = 1'b1;

    // All four requesters send one-byte messages; grants come out 0,1,2,3 two cycles apart.
    $display("[TB] round-robin single-byte messages");
    tick();
    bus.tx_ready   = 1'b1;
    bus.req_tdata  = 32'hA3A2A1A0;
    bus.req_tlast  = 4'hF;
    bus.req_tvalid = 4'hF;
    settle();
    check_idle("t1_arb");
    for (int i = 0; i < NUM_REQ; i++) begin
      tick();
      settle();
      check_grant("t1_grant", i, 8'(8'hA0 + i), 1'b1, 4'(4'b0001 << i));
      tick();
      bus.req_tvalid[i] = 1'b0;
      settle();
      check_idle("t1_gap");
    end

    // Requester 2 keeps the TX for its whole 3-byte message while requester 0 waits.
    $display("[TB] message locking");
    tick();
    apply_stimulus(2, 1'b1, 8'h11, 1'b0);
    apply_stimulus(0, 1'b0, 8'h00, 1'b0);
    settle();
    check_idle("t2_arb");
    tick();
    apply_stimulus(0, 1'b1, 8'h55, 1'b1);
    settle();
    check_grant("t2_b0", 2, 8'h11, 1'b1, 4'b0100);
    tick();
    apply_stimulus(2, 1'b1, 8'h22, 1'b0);
    settle();
    check_grant("t2_b1", 2, 8'h22, 1'b1, 4'b0100);
    tick();
    apply_stimulus(2, 1'b1, 8'h33, 1'b1);
    settle();
    check_grant("t2_b2", 2, 8'h33, 1'b1, 4'b0100);
    tick();
    apply_stimulus(2, 1'b0, 8'h00, 1'b0);
    settle();
    check_idle("t2_rel");
    tick();
    settle();
    check_grant("t2_r0", 0, 8'h55, 1'b1, 4'b0001);
    tick();
    apply_stimulus(0, 1'b0, 8'h00, 1'b0);
    settle();
    check_idle("t2_end");

    // UART busy 9 of every 10 cycles; a stalled tlast byte must not release the grant.
    $display("[TB] slow UART");
    tick();
    bus.tx_ready = 1'b0;
    apply_stimulus(1, 1'b1, 8'h61, 1'b0);
    settle();
    check_idle("t3_arb");
    for (int j = 1; j <= 10; j++) begin
      tick();
      bus.tx_ready = (j == 10);
      settle();
      check_grant("t3_b0", 1, 8'h61, 1'b1, (j == 10) ? 4'b0010 : 4'b0000);
      if (bus.tx_tdata_valid && bus.tx_ready) xfers++;
    end
    for (int j = 1; j <= 10; j++) begin
      tick();
      apply_stimulus(1, 1'b1, 8'h62, 1'b1);
      bus.tx_ready = (j == 10);
      settle();
      check_grant("t3_b1", 1, 8'h62, 1'b1, (j == 10) ? 4'b0010 : 4'b0000);
      if (bus.tx_tdata_valid && bus.tx_ready) xfers++;
    end
    tick();
    apply_stimulus(1, 1'b0, 8'h00, 1'b0);
    bus.tx_ready = 1'b1;
    settle();
    check_idle("t3_rel");
    check_output("t3_xfers", 32'(xfers), 32'd2);

    // Requester 1 goes quiet mid-message; after 8 idle cycles the grant is revoked and requester 3 gets the TX.
    $display("[TB] hold timeout");
    tick();
    apply_stimulus(1, 1'b1, 8'h71, 1'b0);
    settle();
    check_idle("t4_arb");
    tick();
    apply_stimulus(3, 1'b1, 8'h99, 1'b1);
    settle();
    check_grant("t4_b0", 1, 8'h71, 1'b1, 4'b0010);
    tick();
    apply_stimulus(1, 1'b0, 8'h00, 1'b0);
    settle();
    check_grant("t4_hold0", 1, 8'h00, 1'b0, 4'b0010);
    check_output("t4_nopulse0", 32'(bus.timeout_pulse), 32'd0);
    for (int k = 1; k < HOLD_TIMEOUT; k++) begin
      tick();
      settle();
      check_grant("t4_hold", 1, 8'h00, 1'b0, 4'b0010);
      check_output("t4_nopulse", 32'(bus.timeout_pulse), 32'd0);
    end
    tick();
    settle();
    check_output("t4_pulse", 32'(bus.timeout_pulse), 32'd1);
    check_idle("t4_to");
    tick();
    settle();
    check_output("t4_pulse_end", 32'(bus.timeout_pulse), 32'd0);
    check_grant("t4_r3", 3, 8'h99, 1'b1, 4'b1000);
    tick();
    apply_stimulus(3, 1'b0, 8'h00, 1'b0);
    settle();
    check_idle("t4_end");

    // Reset in the middle of a message from requester 1 also restores requester 0's priority.
    $display("[TB] mid-message reset");
    tick();
    bus.tx_ready = 1'b0;
    apply_stimulus(1, 1'b1, 8'h81, 1'b0);
    settle();
    check_idle("t5_arb");
    tick();
    settle();
    check_grant("t5_b0", 1, 8'h81, 1'b1, 4'b0000);
    rstn = 1'b0;
    apply_stimulus(0, 1'b1, 8'h0F, 1'b1);
    settle();
    check_idle("t5_rst");
    check_output("t5_rst_id", 32'(bus.grant_id), 32'd0);
    tick();
    settle();
    check_idle("t5_rst_hold");
    rstn = 1'b1;
    bus.tx_ready = 1'b1;
    settle();
    check_idle("t5_arb2");
    tick();
    settle();
    check_grant("t5_r0", 0, 8'h0F, 1'b1, 4'b0001);
    tick();
    apply_stimulus(0, 1'b0, 8'h00, 1'b0);
    settle();
    check_idle("t5_rel");
    tick();
    settle();
    check_grant("t5_r1", 1, 8'h81, 1'b1, 4'b0010);
    tick();
    apply_stimulus(1, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between NUM_REQ independent byte-stream requesters. Each requester presents an AXI-stream-like message (tdata/tvalid/tready/tlast). Once a requester is granted, it holds the transmitter until its tlast byte has been accepted, or until a hold timeout releases it. The block sits directly in front of the UART TX: it drives the TX data/valid inputs and observes the TX ready output.

## Interface

**Parameters**

- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_BITS`, 8: byte width; must match the UART TX data width.
- `HOLD_TIMEOUT`, 1000: clk cycles the granted requester may hold tvalid low before its grant is revoked; 0 disables the timeout.

**Ports**

- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `req_tdata`  in  NUM_REQ*DATA_BITS  requester i data in bits [i*DATA_BITS +: DATA_BITS]
- `req_tvalid`  in  NUM_REQ  per-requester byte valid
- `req_tlast`  in  NUM_REQ  per-requester last byte of message
- `req_tready`  out  NUM_REQ  per-requester byte accepted
- `tx_tdata`  out  DATA_BITS  to UART TX data
- `tx_tdata_valid`  out  1  to UART TX valid
- `tx_ready`  in  1  from UART TX ready
- `grant_active`  out  1  a requester currently owns the TX
- `grant_id`  out  max(1,clog2(NUM_REQ))  index of the owning requester
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation

- Two states: IDLE and LOCKED.
- **IDLE:**
  - grant_active=0, tx_tdata_valid=0, req_tready=0.
  - If any req_tvalid bit is high, select the first asserted requester, searching upward from (last_grant+1) mod NUM_REQ with wrap-around.
  - Register the selection in grant_id and go to LOCKED.
- **LOCKED:**
  - tx_tdata = req_tdata slice of grant_id.
  - tx_tdata_valid = req_tvalid[grant_id].
  - req_tready[grant_id] = tx_ready; all other req_tready bits are 0.
  - A byte transfers when req_tvalid[grant_id] && tx_ready.
  - Transfer with req_tlast[grant_id]=1: set last_grant <= grant_id and go to IDLE.
  - **Hold counter:**
    - Clears on every cycle in which req_tvalid[grant_id]=1, and on entry to LOCKED.
    - Otherwise increments.
    - When it reaches HOLD_TIMEOUT-1 with tvalid still low, go to IDLE, set last_grant <= grant_id, and pulse timeout_pulse.
    - The counter saturates and never wraps.
- tlast on a byte that does not transfer (tx_ready=0) has no effect.
- Requests from non-granted requesters are ignored in LOCKED; they stay pending and their tvalid is never dropped by this block.
- After reset, last_grant = NUM_REQ-1, so requester 0 has top priority for the first arbitration.
- The combinational paths tx_ready→req_tready and req_tvalid→tx_tdata_valid are permitted. The UART TX ready does not depend on its valid input, so no loop forms.

## Timing

- **Reset values:** state=IDLE, grant_active=0, grant_id=0, tx_tdata=0, tx_tdata_valid=0, req_tready=0, timeout_pulse=0, hold counter=0.
- **Arbitration latency:** req_tvalid high in IDLE at cycle n → grant_active=1 and tx_tdata_valid=1 at cycle n+1. The first byte can transfer at n+1.
- **Release:** tlast transfer at cycle k → IDLE at k+1, with grant_active=0. The earliest next grant (any requester) is at k+2. The minimum inter-message gap at the arbiter is one cycle.
- **Timeout:** tvalid low from cycle m in LOCKED → IDLE at m+HOLD_TIMEOUT, with timeout_pulse high for exactly that cycle.
- **Simultaneous tlast transfer and timeout expiry:** treated as a normal tlast release; timeout_pulse=0.
- **Reset mid-message:** all outputs return to reset values immediately (asynchronous). The partially sent message is abandoned; the requester must restart it.

## Test plan

1. After reset, assert req_tvalid=4'b1111 with single-byte messages (tlast=1), bytes 0xA0..0xA3, tx_ready always 1 → the TX sees 0xA0, 0xA1, 0xA2, 0xA3 in that order, each grant exactly 2 cycles apart.
2. Requester 2 sends 3-byte message 0x11,0x22,0x33 while requester 0 holds tvalid high throughout → all three bytes of requester 2 reach the TX uninterrupted, then requester 0 is granted; grant_id sequence is 2 then 0.
3. Model the UART TX with 10-cycle busy periods (tx_ready low 9 of every 10 cycles) → req_tready pulses only when tx_ready=1; no byte is duplicated or dropped; tlast on a stalled byte holds the grant.
4. HOLD_TIMEOUT=8: requester 1 sends one byte without tlast, then drops tvalid → 8 cycles later timeout_pulse=1 for one cycle and grant_active=0; a pending requester 3 is granted on the next cycle.
5. Assert rstn low for 1 cycle in the middle of a message from requester 1 → tx_tdata_valid=0 and grant_active=0 during reset; after release, requester 0 wins if asserted (priority pointer reset).
